mem_port_arbiter: RTL

//  Shares the single-port unified instruction/data memory between the CPU fetch port and the

---
 rtl/mem_port_arbiter_pkg.sv | 61 ++++++
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter_lane_align.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch / load-store memory port arbiter.
// Provides RV32I funct3 width codes, the response owner enum, the
// registered response tag and small decode helpers for access size
// and alignment.
package mem_arb_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // owner names who used the memory in the grant cycle; ls_gnt/ls_mis
    // track the load/store handshake separately because a misaligned
    // access is granted without touching memory.
    typedef struct packed {
        owner_e     owner;
        logic [2:0] funct3;
        logic [1:0] off;
        logic       ls_we;
        logic       ls_gnt;
        logic       ls_mis;
    } resp_tag_t;

    localparam resp_tag_t TAG_IDLE = '{owner: OWN_NONE, default: '0};

    // Unused funct3 codes (3, 6, 7) fall through to word size.
    function automatic size_e access_size(input logic [2:0] funct3);
        size_e sz;
        case (funct3)
            F3_B, F3_BU: sz = SZ_BYTE;
            F3_H, F3_HU: sz = SZ_HALF;
            F3_W:        sz = SZ_WORD;
            default:     sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        case (access_size(funct3))
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'd0);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core-side (fetch + load/store) handshakes and the
// memory-array command/response signals around mem_port_arbiter.
//   slave  : arbiter view (requests and mem_rdata in, grants/responses/command out)
//   master : environment view (core + memory array)
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [2:0]        ls_funct3;
    logic [31:0]       ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [31:0]       ls_rdata;
    logic              ls_misalign;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_funct3, ls_addr, ls_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_misalign,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_funct3, ls_addr, ls_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_misalign,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// Combinational byte-lane steering for the shared memory port.
//   st_funct3_i/st_off_i/st_wdata_i : store width, byte offset, right-aligned data
//   st_we_c_o/st_wdata_c_o          : byte write enables and lane-shifted data
//   ld_funct3_i/ld_off_i/ld_rdata_i : load width, byte offset, raw memory word
//   ld_data_c_o                     : selected and sign/zero-extended load data
module mem_port_arbiter_lane_align
    import mem_arb_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_we_c_o,
    output logic [31:0] st_wdata_c_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_c_o
);

    // Store: mask and data both move by the byte offset.
    always_comb begin
        st_we_c_o    = 4'b1111;
        st_wdata_c_o = 32'(st_wdata_i << {st_off_i, 3'b000});
        case (access_size(st_funct3_i))
            SZ_BYTE: st_we_c_o = 4'(4'b0001 << st_off_i);
            SZ_HALF: st_we_c_o = 4'(4'b0011 << st_off_i);
            default: st_we_c_o = 4'b1111;
        endcase
    end

    // Load: bring the addressed lane down to bit 0, then extend.
    // funct3[2] set selects the unsigned variants (LBU/LHU).
    logic [31:0] ld_shift;
    logic        ld_signed;

    always_comb begin
        ld_shift    = 32'(ld_rdata_i >> {ld_off_i, 3'b000});
        ld_signed   = ~ld_funct3_i[2];
        ld_data_c_o = ld_rdata_i;
        case (access_size(ld_funct3_i))
            SZ_BYTE: ld_data_c_o = {{24{ld_signed & ld_shift[7]}}, ld_shift[7:0]};
            SZ_HALF: ld_data_c_o = {{16{ld_signed & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data_c_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port instruction/data memory between the fetch port
// and the load/store port. Grants are decided combinationally each cycle
// (load/store has priority unless fetch has been starved MAX_STARVE
// cycles); the memory command is driven in the grant cycle and the
// response is returned exactly one cycle later using a registered tag.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fetch/load-store handshakes and memory command/response
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);

    logic [STARVE_W-1:0] starve_q, starve_d;
    resp_tag_t           tag_q, tag_d;

    logic        ls_size_mis;
    logic        force_if;
    logic        ls_gnt_c;
    logic        ls_mem_c;
    logic        if_gnt_c;

    logic [3:0]  st_we;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    mem_port_arbiter_lane_align u_lane_align (
        .st_funct3_i  (bus.ls_funct3),
        .st_off_i     (bus.ls_addr[1:0]),
        .st_wdata_i   (bus.ls_wdata),
        .st_we_c_o    (st_we),
        .st_wdata_c_o (st_wdata),
        .ld_funct3_i  (tag_q.funct3),
        .ld_off_i     (tag_q.off),
        .ld_rdata_i   (bus.mem_rdata),
        .ld_data_c_o  (ld_data)
    );

    // Grant decision. A misaligned load/store is accepted without using
    // the memory, so fetch may share that cycle.
    always_comb begin
        ls_size_mis = is_misaligned(bus.ls_funct3, bus.ls_addr[1:0]);
        force_if    = bus.if_req && (starve_q == STARVE_W'(MAX_STARVE));
        ls_gnt_c    = !reset && bus.ls_req && !force_if;
        ls_mem_c    = ls_gnt_c && !ls_size_mis;
        if_gnt_c    = !reset && bus.if_req && !ls_mem_c;
    end

    assign bus.if_gnt = if_gnt_c;
    assign bus.ls_gnt = ls_gnt_c;

    // Memory command for the winner; idle cycles drive all zeros.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (ls_mem_c) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.ls_addr[ADDR_W+1:2];
            if (bus.ls_we) begin
                bus.mem_we    = st_we;
                bus.mem_wdata = st_wdata;
            end
        end else if (if_gnt_c) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.if_addr[ADDR_W+1:2];
        end
    end

    // Starvation counter: counts refused fetch cycles, saturating.
    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req || if_gnt_c) begin
            starve_d = '0;
        end else if (starve_q != STARVE_W'(MAX_STARVE)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Response tag captured in the grant cycle.
    always_comb begin
        tag_d = TAG_IDLE;
        if (ls_mem_c) begin
            tag_d.owner = OWN_LS;
        end else if (if_gnt_c) begin
            tag_d.owner = OWN_IF;
        end
        if (ls_gnt_c) begin
            tag_d.funct3 = bus.ls_funct3;
            tag_d.off    = bus.ls_addr[1:0];
            tag_d.ls_we  = bus.ls_we;
            tag_d.ls_gnt = 1'b1;
            tag_d.ls_mis = ls_size_mis;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
            tag_q    <= TAG_IDLE;
        end else begin
            starve_q <= starve_d;
            tag_q    <= tag_d;
        end
    end

    // Responses come from the tag; data is gated so idle/reset reads zero.
    always_comb begin
        bus.if_rvalid   = (tag_q.owner == OWN_IF);
        bus.if_rdata    = (tag_q.owner == OWN_IF) ? bus.mem_rdata : 32'h0;
        bus.ls_rvalid   = tag_q.ls_gnt && !tag_q.ls_mis;
        bus.ls_misalign = tag_q.ls_gnt && tag_q.ls_mis;
        bus.ls_rdata    = (tag_q.owner == OWN_LS && !tag_q.ls_we) ? ld_data : 32'h0;
    end

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                                bus.ls_addr[31:ADDR_W+2]};

endmodule
